regwrite_scheduler: RTL and testbench

//   Controller for the ID-stage register file: one write port shared by the MEM/WB write-back and the branch-link path.
//   Per-register scoreboard of in-flight writes; stalls ID while a source register is pending.

---
 rtl/regwrite_scheduler_if.sv | 47 ++++
 rtl/regwrite_scheduler.sv | 162 ++++++++++++++++
 tb/tb_regwrite_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regwrite_scheduler_if.sv
// Register-file write scheduler bus: ID issue, MEM/WB write-back, link path
// and register-file write port. clock/reset stay plain ports on the block.
interface regwrite_scheduler_if #(
   parameter int unsigned DATA_W = 64
);
   // ID stage
   logic              id_valid;
   logic [4:0]        id_rn;
   logic [4:0]        id_rm;
   logic              id_rn_used;
   logic              id_rm_used;
   logic [4:0]        id_rd;
   logic              id_rd_write;
   logic              id_link;
   logic              id_stall;
   // Write-back request
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   // Link request
   logic              link_valid;
   logic [DATA_W-1:0] link_data;
   logic              link_ready;
   // Register file write port
   logic              rf_write_en;
   logic [4:0]        rf_write_reg;
   logic [DATA_W-1:0] rf_write_data;
   logic              rf_branchlink;
   // Debug
   logic [31:0]       pending_mask;

   // Pipeline side: presents instructions and write requests.
   modport master (
      output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_rd_write, id_link,
      output wb_valid, wb_rd, wb_data, link_valid, link_data,
      input  id_stall, link_ready, rf_write_en, rf_write_reg, rf_write_data, rf_branchlink,
      input  pending_mask
   );

   // Scheduler side.
   modport slave (
      input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_rd_write, id_link,
      input  wb_valid, wb_rd, wb_data, link_valid, link_data,
      output id_stall, link_ready, rf_write_en, rf_write_reg, rf_write_data, rf_branchlink,
      output pending_mask
   );
endinterface

// File: rtl/regwrite_scheduler.sv
// Register-file write scheduler for the ID stage.
// Tracks in-flight writes per register (X0..X30, XZR never tracked), stalls ID on a
// pending source or a saturated destination counter, and arbitrates the single write
// port: write-back first, then a buffered link write, then a direct link write.
// Optional feature: define REGSCHED_SAME_CYCLE_CLEAR_EN when the register file is
// write-before-read, so a commit clears its register's hazard in the same cycle.
module regwrite_scheduler #(
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned LINK_REG = 30
) (
   input logic                clock,
   input logic                reset,
   regwrite_scheduler_if.slave bus
);

   localparam logic [4:0]       LinkReg = 5'(LINK_REG);
   localparam logic [4:0]       Xzr     = 5'd31;
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   // Pending-write counters and the one-entry displaced-link buffer
   logic [CNT_W-1:0]  cnt_q [31];
   logic [CNT_W-1:0]  cnt_d [31];
   logic              lbuf_full_q, lbuf_full_d;
   logic [DATA_W-1:0] lbuf_data_q, lbuf_data_d;

   // Write port selection
   logic              wr_en;
   logic [4:0]        wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic              wr_bl;

   // Per-register decoded views; bit 31 (XZR) is always zero
   logic [31:0] commit_vec;
   logic [31:0] haz_vec;
   logic [31:0] sat_vec;
   logic [31:0] inc_rd_vec;
   logic [31:0] inc_link_vec;

   logic rn_haz, rm_haz, rd_sat, link_sat;
   logic stall, issue;

   // Write port arbitration: write-back, then buffered link, then direct link
   always_comb begin
      wr_en   = 1'b0;
      wr_reg  = Xzr;
      wr_data = '0;
      wr_bl   = 1'b0;
      if (bus.wb_valid) begin
         wr_en   = 1'b1;
         wr_reg  = bus.wb_rd;
         wr_data = bus.wb_data;
      end else if (lbuf_full_q) begin
         wr_en   = 1'b1;
         wr_reg  = LinkReg;
         wr_data = lbuf_data_q;
         wr_bl   = 1'b1;
      end else if (bus.link_valid) begin
         wr_en   = 1'b1;
         wr_reg  = LinkReg;
         wr_data = bus.link_data;
         wr_bl   = 1'b1;
      end
   end

   // Decode the register being committed this cycle (XZR writes retire nothing)
   always_comb begin
      commit_vec = '0;
      if (wr_en && (wr_reg != Xzr)) begin
         commit_vec[wr_reg] = 1'b1;
      end
   end

   // Hazard and saturation per register
   always_comb begin
      haz_vec = '0;
      sat_vec = '0;
      for (int i = 0; i < 31; i++) begin
`ifdef REGSCHED_SAME_CYCLE_CLEAR_EN
         // cnt - commit != 0; the commit is visible to this cycle's read
         haz_vec[i] = (cnt_q[i] != CNT_W'(commit_vec[i]));
`else
         haz_vec[i] = (cnt_q[i] != '0);
`endif
         sat_vec[i] = (cnt_q[i] == CntMax);
      end
   end

   // Stall / issue decision for the instruction in ID
   always_comb begin
      rn_haz   = bus.id_rn_used & (bus.id_rn != Xzr) & haz_vec[bus.id_rn];
      rm_haz   = bus.id_rm_used & (bus.id_rm != Xzr) & haz_vec[bus.id_rm];
      rd_sat   = bus.id_rd_write & (bus.id_rd != Xzr) & sat_vec[bus.id_rd];
      link_sat = bus.id_link & sat_vec[LinkReg];
      stall    = bus.id_valid & (rn_haz | rm_haz | rd_sat | link_sat);
      issue    = bus.id_valid & ~stall;
   end

   // Counter increments for an issuing instruction
   always_comb begin
      inc_rd_vec   = '0;
      inc_link_vec = '0;
      if (issue && bus.id_rd_write && (bus.id_rd != Xzr)) begin
         inc_rd_vec[bus.id_rd] = 1'b1;
      end
      if (issue && bus.id_link) begin
         inc_link_vec[LinkReg] = 1'b1;
      end
   end

   // Counter next state: issue and commit on one register cancel out
   always_comb begin
      for (int i = 0; i < 31; i++) begin
         cnt_d[i] = cnt_q[i] + CNT_W'(inc_rd_vec[i]) + CNT_W'(inc_link_vec[i])
                    - CNT_W'(commit_vec[i]);
      end
   end

   // Link buffer: drains whenever write-back leaves the port free, captures a
   // link request displaced by write-back when empty
   always_comb begin
      lbuf_full_d = lbuf_full_q;
      lbuf_data_d = lbuf_data_q;
      if (lbuf_full_q) begin
         if (!bus.wb_valid) begin
            lbuf_full_d = 1'b0;
         end
      end else if (bus.wb_valid && bus.link_valid) begin
         lbuf_full_d = 1'b1;
         lbuf_data_d = bus.link_data;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '{default: '0};
         lbuf_full_q <= 1'b0;
         lbuf_data_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         lbuf_full_q <= lbuf_full_d;
         lbuf_data_q <= lbuf_data_d;
      end
   end

   // Debug view of non-zero counters
   always_comb begin
      bus.pending_mask = '0;
      for (int i = 0; i < 31; i++) begin
         bus.pending_mask[i] = (cnt_q[i] != '0);
      end
   end

   assign bus.id_stall      = stall;
   assign bus.link_ready    = ~lbuf_full_q;
   assign bus.rf_write_en   = wr_en;
   assign bus.rf_write_reg  = wr_reg;
   assign bus.rf_write_data = wr_data;
   assign bus.rf_branchlink = wr_bl;

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Self-checking bench for regwrite_scheduler: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model (counts per register and a queue for the link buffer).
module tb_regwrite_scheduler;

   localparam int unsigned CNT_W    = 2;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned LINK_REG = 30;
   localparam int          MaxCnt   = (1 << CNT_W) - 1;
`ifdef REGSCHED_SAME_CYCLE_CLEAR_EN
   localparam bit SameCycle = 1'b1;
`else
   localparam bit SameCycle = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   regwrite_scheduler_if #(.DATA_W(DATA_W)) bus ();

   regwrite_scheduler #(
      .CNT_W   (CNT_W),
      .DATA_W  (DATA_W),
      .LINK_REG(LINK_REG)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   int                m_cnt [32];
   logic [DATA_W-1:0] m_lbuf [$];
   int                wb_owed [32];
   int                link_owed;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_cnt[r]   = 0;
         wb_owed[r] = 0;
      end
      m_lbuf.delete();
      link_owed = 0;
   endtask

   task automatic idle();
      bus.id_valid    = 1'b0;
      bus.id_rn       = 5'd0;
      bus.id_rm       = 5'd0;
      bus.id_rn_used  = 1'b0;
      bus.id_rm_used  = 1'b0;
      bus.id_rd       = 5'd0;
      bus.id_rd_write = 1'b0;
      bus.id_link     = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 5'd0;
      bus.wb_data     = '0;
      bus.link_valid  = 1'b0;
      bus.link_data   = '0;
   endtask

   // Start of a cycle: just after the rising edge, inputs back to idle
   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   function automatic bit hazard(input int r, input int commit);
      int eff;
      if (r == 31) return 1'b0;
      eff = m_cnt[r];
      if (SameCycle && (commit == r)) eff--;
      return eff != 0;
   endfunction

   // Compare outputs against the model at the falling edge, then advance it
   task automatic step();
      bit                e_en, e_bl, e_stall, issue;
      int                e_reg, commit;
      logic [DATA_W-1:0] e_data;
      logic [31:0]       e_mask;
      @(negedge clock);
      if (!reset) model_reset();
      e_en = 1'b0; e_bl = 1'b0; e_reg = 31; e_data = '0;
      if (bus.wb_valid) begin
         e_en = 1'b1; e_reg = int'(bus.wb_rd); e_data = bus.wb_data;
      end else if (m_lbuf.size() > 0) begin
         e_en = 1'b1; e_reg = LINK_REG; e_data = m_lbuf[0]; e_bl = 1'b1;
      end else if (bus.link_valid) begin
         e_en = 1'b1; e_reg = LINK_REG; e_data = bus.link_data; e_bl = 1'b1;
      end
      commit = (e_en && e_reg != 31) ? e_reg : -1;
      e_stall = bus.id_valid && (
                  (bus.id_rn_used && hazard(int'(bus.id_rn), commit)) ||
                  (bus.id_rm_used && hazard(int'(bus.id_rm), commit)) ||
                  (bus.id_rd_write && bus.id_rd != 5'd31 && m_cnt[bus.id_rd] == MaxCnt) ||
                  (bus.id_link && m_cnt[LINK_REG] == MaxCnt));
      e_mask = '0;
      for (int r = 0; r < 31; r++) e_mask[r] = (m_cnt[r] != 0);

      check("id_stall", 64'(bus.id_stall), 64'(e_stall));
      check("link_ready", 64'(bus.link_ready), 64'(m_lbuf.size() == 0));
      check("rf_write_en", 64'(bus.rf_write_en), 64'(e_en));
      check("pending_mask", 64'(bus.pending_mask), 64'(e_mask));
      if (e_en) begin
         check("rf_write_reg", 64'(bus.rf_write_reg), 64'(e_reg));
         check("rf_write_data", 64'(bus.rf_write_data), 64'(e_data));
         check("rf_branchlink", 64'(bus.rf_branchlink), 64'(e_bl));
      end

      if (reset) begin
         issue = bus.id_valid && !e_stall;
         if (issue && bus.id_rd_write && bus.id_rd != 5'd31) begin
            m_cnt[bus.id_rd]++;
            wb_owed[bus.id_rd]++;
         end
         if (issue && bus.id_link) begin
            m_cnt[LINK_REG]++;
            link_owed++;
         end
         if (commit >= 0) m_cnt[commit]--;
         if (bus.wb_valid && bus.wb_rd != 5'd31) wb_owed[bus.wb_rd]--;
         if (m_lbuf.size() > 0) begin
            if (!bus.wb_valid) void'(m_lbuf.pop_front());
         end else if (bus.link_valid) begin
            link_owed--;
            if (bus.wb_valid) m_lbuf.push_back(bus.link_data);
         end
      end
   endtask

   function automatic logic [4:0] pick_reg();
      int v;
      v = $urandom_range(0, 9);
      if (v < 7) return 5'(v);
      return (v == 7) ? 5'd30 : 5'd31;
   endfunction

   task automatic random_inputs();
      int start, r;
      bit found;
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_rn       = pick_reg();
      bus.id_rm       = pick_reg();
      bus.id_rn_used  = 1'($urandom_range(0, 1));
      bus.id_rm_used  = 1'($urandom_range(0, 1));
      bus.id_link     = ($urandom_range(0, 7) == 0);
      bus.id_rd_write = !bus.id_link && ($urandom_range(0, 1) == 1);
      bus.id_rd       = pick_reg();
      bus.wb_data     = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
         found = 1'b0;
         start = $urandom_range(0, 31);
         for (int k = 0; k < 32; k++) begin
            r = (start + k) % 32;
            if (!found && r != 31 && wb_owed[r] > 0) begin
               found = 1'b1;
               bus.wb_valid = 1'b1;
               bus.wb_rd = 5'(r);
            end
         end
         if (!found && $urandom_range(0, 3) == 0) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd = 5'd31;
         end
      end
      bus.link_data = {$urandom, $urandom};
      bus.link_valid = (link_owed > 0) && ($urandom_range(0, 1) == 1);
   endtask

   initial begin
      idle();
      model_reset();
      #1;
      check("reset_stall", 64'(bus.id_stall), 64'd0);
      check("reset_link_ready", 64'(bus.link_ready), 64'd1);
      check("reset_mask", 64'(bus.pending_mask), 64'd0);
      check("reset_wr_en", 64'(bus.rf_write_en), 64'd0);
      #11 reset = 1'b1;

      // Write-back and link collide: write-back first, link from the buffer next
      tick(); bus.id_valid = 1; bus.id_rd = 5'd3; bus.id_rd_write = 1; step();
      tick(); bus.id_valid = 1; bus.id_link = 1; step();
      tick(); bus.wb_valid = 1; bus.wb_rd = 5'd3; bus.wb_data = 64'hAAAA;
      bus.link_valid = 1; bus.link_data = 64'h1004; step();
      check("collide_wb_reg", 64'(bus.rf_write_reg), 64'd3);
      check("collide_wb_bl", 64'(bus.rf_branchlink), 64'd0);
      tick(); step();
      check("drain_reg", 64'(bus.rf_write_reg), 64'd30);
      check("drain_data", 64'(bus.rf_write_data), 64'h1004);
      check("drain_bl", 64'(bus.rf_branchlink), 64'd1);
      check("drain_link_ready", 64'(bus.link_ready), 64'd0);
      tick(); step();
      check("after_drain_mask", 64'(bus.pending_mask), 64'd0);

      // RAW on X5 with write-back three cycles after issue
      tick(); bus.id_valid = 1; bus.id_rd = 5'd5; bus.id_rd_write = 1; step();
      for (int c = 0; c < 2; c++) begin
         tick(); bus.id_valid = 1; bus.id_rn = 5'd5; bus.id_rn_used = 1; step();
         check("raw_wait_stall", 64'(bus.id_stall), 64'd1);
      end
      tick(); bus.id_valid = 1; bus.id_rn = 5'd5; bus.id_rn_used = 1;
      bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 64'h55; step();
      check("raw_commit_stall", 64'(bus.id_stall), 64'(!SameCycle));
      tick(); bus.id_valid = 1; bus.id_rn = 5'd5; bus.id_rn_used = 1; step();
      check("raw_after_stall", 64'(bus.id_stall), 64'd0);

      // Saturation on X7: three issue, the fourth waits for a commit
      for (int c = 0; c < 3; c++) begin
         tick(); bus.id_valid = 1; bus.id_rd = 5'd7; bus.id_rd_write = 1; step();
         check("x7_issue_stall", 64'(bus.id_stall), 64'd0);
      end
      tick(); bus.id_valid = 1; bus.id_rd = 5'd7; bus.id_rd_write = 1; step();
      check("x7_sat_stall", 64'(bus.id_stall), 64'd1);
      check("x7_mask", 64'(bus.pending_mask[7]), 64'd1);
      tick(); bus.id_valid = 1; bus.id_rd = 5'd7; bus.id_rd_write = 1;
      bus.wb_valid = 1; bus.wb_rd = 5'd7; step();
      check("x7_commit_stall", 64'(bus.id_stall), 64'd1);
      tick(); bus.id_valid = 1; bus.id_rd = 5'd7; bus.id_rd_write = 1; step();
      check("x7_resume_stall", 64'(bus.id_stall), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick(); bus.wb_valid = 1; bus.wb_rd = 5'd7; step();
      end

      // XZR is never tracked
      tick(); bus.id_valid = 1; bus.id_rd = 5'd31; bus.id_rd_write = 1; step();
      tick(); bus.id_valid = 1; bus.id_rn = 5'd31; bus.id_rn_used = 1;
      bus.id_rm = 5'd31; bus.id_rm_used = 1; bus.id_rd = 5'd31; bus.id_rd_write = 1; step();
      check("xzr_stall", 64'(bus.id_stall), 64'd0);
      check("xzr_mask31", 64'(bus.pending_mask[31]), 64'd0);
      tick(); bus.wb_valid = 1; bus.wb_rd = 5'd31; step();
      check("xzr_wr_en", 64'(bus.rf_write_en), 64'd1);
      check("xzr_wr_reg", 64'(bus.rf_write_reg), 64'd31);
      check("xzr_mask_all", 64'(bus.pending_mask), 64'd0);

      // Issue and commit on X9 in one cycle keep the count at 1
      tick(); bus.id_valid = 1; bus.id_rd = 5'd9; bus.id_rd_write = 1; step();
      tick(); bus.id_valid = 1; bus.id_rd = 5'd9; bus.id_rd_write = 1;
      bus.wb_valid = 1; bus.wb_rd = 5'd9; step();
      check("x9_same_stall", 64'(bus.id_stall), 64'd0);
      tick(); step();
      check("x9_still_pending", 64'(bus.pending_mask[9]), 64'd1);
      tick(); bus.wb_valid = 1; bus.wb_rd = 5'd9; step();
      tick(); step();
      check("x9_cleared", 64'(bus.pending_mask), 64'd0);

      // Asynchronous reset with X5 pending twice and the link buffer full
      tick(); bus.id_valid = 1; bus.id_rd = 5'd5; bus.id_rd_write = 1; step();
      tick(); bus.id_valid = 1; bus.id_rd = 5'd5; bus.id_rd_write = 1; step();
      tick(); bus.id_valid = 1; bus.id_link = 1; step();
      tick(); bus.wb_valid = 1; bus.wb_rd = 5'd31;
      bus.link_valid = 1; bus.link_data = 64'h2008; step();
      tick(); bus.id_valid = 1; bus.id_rn = 5'd5; bus.id_rn_used = 1;
      bus.wb_valid = 1; bus.wb_rd = 5'd31;
      #1;
      check("pre_reset_stall", 64'(bus.id_stall), 64'd1);
      check("pre_reset_link_ready", 64'(bus.link_ready), 64'd0);
      reset = 1'b0;
      #1;
      check("async_reset_stall", 64'(bus.id_stall), 64'd0);
      check("async_reset_link_ready", 64'(bus.link_ready), 64'd1);
      check("async_reset_mask", 64'(bus.pending_mask), 64'd0);
      step();
      #1 reset = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         random_inputs();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
